// File: rtl/mvu_jobctl.sv
// Job sequencer for the MVU address generators: clear, issue a fixed number of
// non-stalled steps, drain the datapath pipeline, pulse done; realigns AGU flags.
module mvu_jobctl #(
    parameter int unsigned BCNT    = 32,
    parameter int unsigned PIPELAT = 3
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            start,
    input  logic [BCNT-1:0] countdown,
    input  logic            stall,
    input  logic            sh_in,
    input  logic            imsb_in,
    input  logic            wmsb_in,
    output logic            agu_clr,
    output logic            agu_en,
    output logic            busy,
    output logic            done,
    output logic            valid_d,
    output logic            sh_d,
    output logic            imsb_d,
    output logic            wmsb_d
);

    localparam int unsigned DW = (PIPELAT > 1) ? $clog2(PIPELAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [BCNT-1:0] r_rem;
    logic [DW-1:0]   r_dcnt;
    logic [3:0]      r_dly [PIPELAT];
    logic            w_step;
    logic [3:0]      w_tap;

    assign w_step = (r_state == S_RUN) && !stall;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_dcnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rem   <= countdown;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_state <= (r_rem == '0) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    if (w_step) begin
                        if (r_rem != '0) begin
                            r_rem <= r_rem - BCNT'(1);
                        end
                        if (r_rem == BCNT'(1)) begin
                            r_dcnt  <= DW'(PIPELAT - 1);
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Stall is ignored here: the pipeline drains unconditionally.
                    if (r_dcnt == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_dcnt <= r_dcnt - DW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Delay lines {valid, sh, imsb, wmsb}; shift every cycle regardless of state.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < int'(PIPELAT); i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_dly[0] <= {w_step, sh_in, imsb_in, wmsb_in};
            for (int i = 1; i < int'(PIPELAT); i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign w_tap   = r_dly[PIPELAT-1];

    assign agu_clr = (r_state == S_CLEAR);
    assign agu_en  = w_step;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign valid_d = w_tap[3];
    assign sh_d    = w_tap[2] & w_tap[3];
    assign imsb_d  = w_tap[1] & w_tap[3];
    assign wmsb_d  = w_tap[0] & w_tap[3];

endmodule

// File: tb/tb_mvu_jobctl.sv
// Directed bench for mvu_jobctl (BCNT=32, PIPELAT=3); per-cycle output vectors
// packed as {agu_clr, agu_en, busy, done, valid_d, sh_d, imsb_d, wmsb_d}.
module tb_mvu_jobctl;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic [31:0] countdown;
    logic        stall;
    logic        sh_in;
    logic        imsb_in;
    logic        wmsb_in;
    logic        agu_clr;
    logic        agu_en;
    logic        busy;
    logic        done;
    logic        valid_d;
    logic        sh_d;
    logic        imsb_d;
    logic        wmsb_d;

    int n_vec;
    int n_err;

    mvu_jobctl #(
        .BCNT    (32),
        .PIPELAT (3)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .countdown (countdown),
        .stall     (stall),
        .sh_in     (sh_in),
        .imsb_in   (imsb_in),
        .wmsb_in   (wmsb_in),
        .agu_clr   (agu_clr),
        .agu_en    (agu_en),
        .busy      (busy),
        .done      (done),
        .valid_d   (valid_d),
        .sh_d      (sh_d),
        .imsb_d    (imsb_d),
        .wmsb_d    (wmsb_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset asserted together with start and flags; reset must win.
    task automatic test_reset();
        logic [7:0] obs;
        clr_n = 1'b0; start = 1'b1; countdown = 32'd5; stall = 1'b0;
        sh_in = 1'b1; imsb_in = 1'b1; wmsb_in = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 3; c++) begin
            clr_n   = (c >= 2);
            start   = (c == 1);
            sh_in   = 1'b0; imsb_in = 1'b0; wmsb_in = 1'b0;
            @(negedge clk);
            obs = {agu_clr, agu_en, busy, done, valid_d, sh_d, imsb_d, wmsb_d};
            n_vec++;
            if (obs !== 8'b0) begin
                n_err++;
                $display("FAIL reset cycle %0d: got %b expected %b", c, obs, 8'b0);
            end
            @(posedge clk); #1;
        end
    endtask

    // Basic 4-step job with ignored starts in RUN/DONE and flag alignment.
    task automatic test_basic();
        logic [7:0] obs, exp;
        for (int c = 0; c < 12; c++) begin
            start     = (c == 0) || (c == 3) || (c == 9);
            countdown = (c == 0) ? 32'd4 : 32'd7;
            stall     = 1'b0;
            sh_in     = (c == 4);
            imsb_in   = (c == 4);
            wmsb_in   = (c == 5);
            @(negedge clk);
            obs = {agu_clr, agu_en, busy, done, valid_d, sh_d, imsb_d, wmsb_d};
            exp = {c == 1, c >= 2 && c <= 5, c >= 1 && c <= 9, c == 9,
                   c >= 5 && c <= 8, c == 7, c == 7, c == 8};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL basic cycle %0d: got %b expected %b", c, obs, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    // Stall in RUN cycles 3-4 (flag raised while stalled), stall in DRAIN ignored.
    task automatic test_stall();
        logic [7:0] obs, exp;
        for (int c = 0; c < 14; c++) begin
            start     = (c == 0);
            countdown = 32'd4;
            stall     = (c == 3) || (c == 4) || (c == 9);
            sh_in     = (c == 3);
            imsb_in   = 1'b0;
            wmsb_in   = 1'b0;
            @(negedge clk);
            obs = {agu_clr, agu_en, busy, done, valid_d, sh_d, imsb_d, wmsb_d};
            exp = {c == 1, c == 2 || (c >= 5 && c <= 7), c >= 1 && c <= 11, c == 11,
                   c == 5 || (c >= 8 && c <= 10), 1'b0, 1'b0, 1'b0};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL stall cycle %0d: got %b expected %b", c, obs, exp);
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
    endtask

    // Zero-length job: CLEAR straight to DONE.
    task automatic test_zero();
        logic [7:0] obs, exp;
        for (int c = 0; c < 6; c++) begin
            start     = (c == 0);
            countdown = 32'd0;
            @(negedge clk);
            obs = {agu_clr, agu_en, busy, done, valid_d, sh_d, imsb_d, wmsb_d};
            exp = {c == 1, 1'b0, c == 1 || c == 2, c == 2, 1'b0, 1'b0, 1'b0, 1'b0};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL zero cycle %0d: got %b expected %b", c, obs, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    // Single-step job: RUN lasts one cycle.
    task automatic test_one();
        logic [7:0] obs, exp;
        for (int c = 0; c < 8; c++) begin
            start     = (c == 0);
            countdown = 32'd1;
            wmsb_in   = (c == 2);
            @(negedge clk);
            obs = {agu_clr, agu_en, busy, done, valid_d, sh_d, imsb_d, wmsb_d};
            exp = {c == 1, c == 2, c >= 1 && c <= 6, c == 6, c == 5, 1'b0, 1'b0, c == 5};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL one cycle %0d: got %b expected %b", c, obs, exp);
            end
            @(posedge clk); #1;
        end
        wmsb_in = 1'b0;
    endtask

    // Flags toggling while idle never reach the outputs.
    task automatic test_flags_idle();
        logic [7:0] obs;
        for (int c = 0; c < 5; c++) begin
            start   = 1'b0;
            sh_in   = 1'b1; imsb_in = 1'b1; wmsb_in = 1'b1;
            @(negedge clk);
            obs = {agu_clr, agu_en, busy, done, valid_d, sh_d, imsb_d, wmsb_d};
            n_vec++;
            if (obs !== 8'b0) begin
                n_err++;
                $display("FAIL flags_idle cycle %0d: got %b expected %b", c, obs, 8'b0);
            end
            @(posedge clk); #1;
        end
        sh_in = 1'b0; imsb_in = 1'b0; wmsb_in = 1'b0;
    endtask

    // start held high: ignored until the cycle after DONE, then a second job runs.
    task automatic test_back_to_back();
        logic [7:0] obs, exp;
        for (int c = 0; c < 17; c++) begin
            start     = (c <= 8);
            countdown = 32'd2;
            @(negedge clk);
            obs = {agu_clr, agu_en, busy, done, valid_d, sh_d, imsb_d, wmsb_d};
            exp = {c == 1 || c == 9,
                   c == 2 || c == 3 || c == 10 || c == 11,
                   (c >= 1 && c <= 7) || (c >= 9 && c <= 15),
                   c == 7 || c == 15,
                   c == 5 || c == 6 || c == 13 || c == 14,
                   1'b0, 1'b0, 1'b0};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", c, obs, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    // Reset during RUN abandons the job; a fresh 3-step job follows.
    task automatic test_reset_midjob();
        logic [7:0] obs, exp;
        for (int c = 0; c < 16; c++) begin
            clr_n     = (c != 4);
            start     = (c == 0) || (c == 6);
            countdown = (c == 6) ? 32'd3 : 32'd4;
            @(negedge clk);
            obs = {agu_clr, agu_en, busy, done, valid_d, sh_d, imsb_d, wmsb_d};
            exp = {c == 1 || c == 7,
                   (c >= 2 && c <= 4) || (c >= 8 && c <= 10),
                   (c >= 1 && c <= 4) || (c >= 7 && c <= 14),
                   c == 14,
                   c >= 11 && c <= 13,
                   1'b0, 1'b0, 1'b0};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset_midjob cycle %0d: got %b expected %b", c, obs, exp);
            end
            @(posedge clk); #1;
        end
        clr_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_one();
        test_flags_idle();
        test_back_to_back();
        test_reset_midjob();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
